// File: rtl/te_bm_pkg.sv
// Shared types and constants for the buffer-memory port engines.
// FIFO entries carry the burst-last flag at the MSB above the data word.
package te_bm_pkg;

  localparam int unsigned BM_AWIDTH_DEF = 10;
  localparam int unsigned BM_DWIDTH_DEF = 64;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  // Bit index of the last flag in a FIFO entry holding a dwidth-bit word.
  function automatic int unsigned te_entry_last_idx(input int unsigned dwidth);
    return dwidth;
  endfunction

endpackage

// File: rtl/te_ob_fifo.sv
// Small synchronous FIFO with occupancy count; read data is taken straight
// from the storage registers at the read pointer.
module te_ob_fifo #(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone defines valid entries.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/te_ob_bm_rd.sv
// Outbound burst read engine: walks a command's address range on the BM port,
// holding requests back so every granted word is guaranteed a FIFO slot.
module te_ob_bm_rd
  import te_bm_pkg::*;
#(
  parameter int unsigned BM_AWIDTH  = BM_AWIDTH_DEF,
  parameter int unsigned BM_DWIDTH  = BM_DWIDTH_DEF,
  parameter int unsigned LEN_WIDTH  = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [BM_AWIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  output logic                 ob_bm_req,
  output logic                 ob_bm_last,
  output logic [BM_AWIDTH-1:0] ob_bm_addr,
  input  logic                 bm_ob_gnt,
  input  logic [BM_DWIDTH-1:0] bm_ob_rdata,
  output logic                 pkt_valid,
  input  logic                 pkt_ready,
  output logic [BM_DWIDTH-1:0] pkt_data,
  output logic                 pkt_last,
  output logic                 busy
);

  localparam int unsigned LAST_IDX = te_entry_last_idx(BM_DWIDTH);
  localparam int unsigned EW       = LAST_IDX + 1;
  localparam int unsigned CW       = $clog2(FIFO_DEPTH) + 1;

  state_e               state_q, state_d;
  logic [BM_AWIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
  logic                 inflight_q, inflight_d;
  logic                 inflight_last_q, inflight_last_d;

  logic                 cmd_acc, gnt_eff, credit_ok, pop;
  logic [CW-1:0]        fifo_count;
  logic                 fifo_full, fifo_empty;
  logic [EW-1:0]        fifo_rdata;

  // Credit counts the word already read but not yet pushed; pops are ignored.
  assign credit_ok = ({1'b0, fifo_count} + (CW+1)'(inflight_q)) < (CW+1)'(FIFO_DEPTH);
  assign cmd_acc   = cmd_valid && cmd_ready;
  assign gnt_eff   = bm_ob_gnt && ob_bm_req;
  assign pop       = pkt_valid && pkt_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (cmd_valid) state_d = BURST;
      BURST: if (gnt_eff && (remaining_q == '0)) state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready  = 1'b0;
    ob_bm_req  = 1'b0;
    ob_bm_last = 1'b0;
    ob_bm_addr = cur_addr_q;
    busy       = inflight_q || !fifo_empty;
    unique case (state_q)
      IDLE:  cmd_ready = 1'b1;
      BURST: begin
        ob_bm_req  = credit_ok;
        ob_bm_last = (remaining_q == '0);
        busy       = 1'b1;
      end
    endcase
  end

  always_comb begin
    cur_addr_d      = cur_addr_q;
    remaining_d     = remaining_q;
    inflight_d      = gnt_eff;
    inflight_last_d = inflight_last_q;
    if (cmd_acc) begin
      cur_addr_d  = cmd_addr;
      remaining_d = cmd_len;
    end else if (gnt_eff) begin
      cur_addr_d      = cur_addr_q + BM_AWIDTH'(1);
      remaining_d     = remaining_q - LEN_WIDTH'(1);
      inflight_last_d = ob_bm_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr_q      <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      cur_addr_q      <= cur_addr_d;
      remaining_q     <= remaining_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  te_ob_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .wdata ({inflight_last_q, bm_ob_rdata}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign pkt_valid = !fifo_empty;
  assign pkt_last  = !fifo_empty && fifo_rdata[LAST_IDX];
  assign pkt_data  = fifo_rdata[BM_DWIDTH-1:0];

  a_credit_ok : assert property (@(posedge clk) disable iff (rst) !(inflight_q && fifo_full));

endmodule

// File: tb/tb_te_ob_bm_rd.sv
// Directed bench for te_ob_bm_rd: a memory model answers grants and a
// scoreboard holds expected addresses and words queued at command acceptance.
module tb_te_ob_bm_rd;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 64;
  localparam int unsigned LW = 8;
  localparam int unsigned FD = 4;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          ob_bm_req;
  logic          ob_bm_last;
  logic [AW-1:0] ob_bm_addr;
  logic          bm_ob_gnt;
  logic [DW-1:0] bm_ob_rdata;
  logic          pkt_valid;
  logic          pkt_ready;
  logic [DW-1:0] pkt_data;
  logic          pkt_last;
  logic          busy;

  te_ob_bm_rd #(
    .BM_AWIDTH (AW), .BM_DWIDTH (DW), .LEN_WIDTH (LW), .FIFO_DEPTH (FD)
  ) dut (
    .clk (clk), .rst (rst),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready),
    .cmd_addr (cmd_addr), .cmd_len (cmd_len),
    .ob_bm_req (ob_bm_req), .ob_bm_last (ob_bm_last), .ob_bm_addr (ob_bm_addr),
    .bm_ob_gnt (bm_ob_gnt), .bm_ob_rdata (bm_ob_rdata),
    .pkt_valid (pkt_valid), .pkt_ready (pkt_ready),
    .pkt_data (pkt_data), .pkt_last (pkt_last),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_grants = 0;
  int n_pkts   = 0;
  int n_cmds   = 0;
  int last_gnt_cyc = -1;
  int last_acc_cyc = -1;

  logic [AW:0] aq[$];
  logic [DW:0] dq[$];
  logic        gnt_alt = 1'b0;
  logic        hold_v  = 1'b0;
  logic [AW-1:0] hold_addr = '0;

  function automatic logic [DW-1:0] memfn(input logic [AW-1:0] a);
    return {22'h15A5A5, a, 22'h0C3C3C, ~a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, scoreboard grants/pops, then model the BM read.
  task automatic tick();
    logic          g;
    logic [AW-1:0] ga;
    logic [AW:0]   ea;
    logic [DW:0]   ed;
    @(negedge clk);
    g  = bm_ob_gnt && ob_bm_req;
    ga = ob_bm_addr;
    if (hold_v && ob_bm_req) chk("addr_hold", 64'(ob_bm_addr), 64'(hold_addr));
    hold_v    = ob_bm_req && !bm_ob_gnt;
    hold_addr = ob_bm_addr;
    if (cmd_valid && cmd_ready) begin
      for (int i = 0; i <= int'(cmd_len); i++) begin
        ea = {(i == int'(cmd_len)), AW'(cmd_addr + AW'(i))};
        aq.push_back(ea);
        dq.push_back({ea[AW], memfn(ea[AW-1:0])});
      end
      n_cmds++;
      last_acc_cyc = cyc;
    end
    if (g) begin
      n_grants++;
      if (ob_bm_last) last_gnt_cyc = cyc;
      chk("gnt_expected", 64'(aq.size() != 0), 64'd1);
      if (aq.size() != 0) begin
        ea = aq.pop_front();
        chk("gnt_addr", 64'(ob_bm_addr), 64'(ea[AW-1:0]));
        chk("gnt_last", 64'(ob_bm_last), 64'(ea[AW]));
      end
    end
    if (pkt_valid && pkt_ready) begin
      n_pkts++;
      chk("pkt_expected", 64'(dq.size() != 0), 64'd1);
      if (dq.size() != 0) begin
        ed = dq.pop_front();
        chk("pkt_data", pkt_data, ed[DW-1:0]);
        chk("pkt_last", 64'(pkt_last), 64'(ed[DW]));
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    bm_ob_rdata = g ? memfn(ga) : {32'hBAD0_0000, 32'(cyc)};
    if (gnt_alt) bm_ob_gnt = ((cyc % 2) == 0);
  endtask

  task automatic drain(input string tag);
    int i;
    i = 0;
    while (i < 300 && !(aq.size() == 0 && dq.size() == 0 && !busy)) begin
      tick();
      i++;
    end
    chk(tag, 64'(aq.size() + dq.size() + int'(busy)), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, p0, c0, acc1, lg1, k;
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    bm_ob_gnt = 1'b0; bm_ob_rdata = '0; pkt_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_req", 64'(ob_bm_req), 64'd0);
    chk("rst_last", 64'(ob_bm_last), 64'd0);
    chk("rst_addr", 64'(ob_bm_addr), 64'd0);
    chk("rst_pkt_valid", 64'(pkt_valid), 64'd0);
    chk("rst_pkt_last", 64'(pkt_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    // 1: single word, exact latency
    bm_ob_gnt = 1'b1;
    cmd_valid = 1'b1; cmd_addr = 10'h010; cmd_len = 8'd0;
    tick();
    cmd_valid = 1'b0;
    chk("t1_req_c1", 64'(ob_bm_req), 64'd1);
    chk("t1_last_c1", 64'(ob_bm_last), 64'd1);
    chk("t1_addr_c1", 64'(ob_bm_addr), 64'h010);
    tick();
    chk("t1_req_c2", 64'(ob_bm_req), 64'd0);
    chk("t1_cmd_ready_c2", 64'(cmd_ready), 64'd1);
    chk("t1_pkt_valid_c2", 64'(pkt_valid), 64'd0);
    tick();
    chk("t1_pkt_valid_c3", 64'(pkt_valid), 64'd1);
    chk("t1_pkt_last_c3", 64'(pkt_last), 64'd1);
    chk("t1_pkt_data_c3", pkt_data, memfn(10'h010));
    drain("t1_drain");

    // 2: 4-word burst with alternating grant
    g0 = n_grants; p0 = n_pkts;
    gnt_alt = 1'b1;
    cmd_valid = 1'b1; cmd_addr = 10'h100; cmd_len = 8'd3;
    tick();
    cmd_valid = 1'b0;
    drain("t2_drain");
    gnt_alt = 1'b0; bm_ob_gnt = 1'b1;
    chk("t2_grants", 64'(n_grants - g0), 64'd4);
    chk("t2_pkts", 64'(n_pkts - p0), 64'd4);

    // 3: backpressure limits grants to FIFO depth
    g0 = n_grants; p0 = n_pkts;
    pkt_ready = 1'b0;
    cmd_valid = 1'b1; cmd_addr = 10'h040; cmd_len = 8'd7;
    tick();
    cmd_valid = 1'b0;
    repeat (10) tick();
    chk("t3_grants_stalled", 64'(n_grants - g0), 64'(FD));
    chk("t3_req_stalled", 64'(ob_bm_req), 64'd0);
    chk("t3_pkt_valid_stalled", 64'(pkt_valid), 64'd1);
    pkt_ready = 1'b1;
    tick();
    chk("t3_req_resumed", 64'(ob_bm_req), 64'd1);
    drain("t3_drain");
    chk("t3_pkts", 64'(n_pkts - p0), 64'd8);

    // 4: address wrap
    g0 = n_grants;
    cmd_valid = 1'b1; cmd_addr = 10'h3FE; cmd_len = 8'd3;
    tick();
    cmd_valid = 1'b0;
    drain("t4_drain");
    chk("t4_grants", 64'(n_grants - g0), 64'd4);

    // 5: reset during third grant
    cmd_valid = 1'b1; cmd_addr = 10'h080; cmd_len = 8'd7;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    chk("t5_req_at_g3", 64'(ob_bm_req), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    aq.delete(); dq.delete(); hold_v = 1'b0;
    chk("t5_req", 64'(ob_bm_req), 64'd0);
    chk("t5_pkt_valid", 64'(pkt_valid), 64'd0);
    chk("t5_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("t5_busy", 64'(busy), 64'd0);
    p0 = n_pkts;
    repeat (4) tick();
    chk("t5_no_stray_pkt", 64'(n_pkts - p0), 64'd0);
    chk("t5_pkt_valid_later", 64'(pkt_valid), 64'd0);

    // 6: back-to-back commands
    p0 = n_pkts; c0 = n_cmds;
    cmd_valid = 1'b1; cmd_addr = 10'h200; cmd_len = 8'd1;
    tick();
    chk("t6_first_accept", 64'(n_cmds - c0), 64'd1);
    cmd_addr = 10'h220;
    k = 0;
    while (n_cmds < c0 + 2 && k < 20) begin
      tick();
      k++;
    end
    cmd_valid = 1'b0;
    acc1 = last_acc_cyc; lg1 = last_gnt_cyc;
    chk("t6_second_accept", 64'(n_cmds - c0), 64'd2);
    chk("t6_accept_after_last_gnt", 64'(acc1), 64'(lg1 + 1));
    drain("t6_drain");
    chk("t6_pkts", 64'(n_pkts - p0), 64'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
